// File: rtl/slicewrite_regbank_if.sv
// Bus bundle for slicewrite_regbank: per-channel write request and per-bank state.
interface slicewrite_regbank_if #(
  parameter int NCHAN = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int CW    = 8
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NCHAN-1:0]             wr_en;
  logic [NCHAN*IW-1:0]          wr_idx;
  logic [NCHAN*WIDTH-1:0]       wr_data;
  logic [NCHAN-1:0]             clr;
  logic [NCHAN*DEPTH*WIDTH-1:0] out;
  logic [NCHAN*DEPTH-1:0]       valid;
  logic [NCHAN*CW-1:0]          wr_count;
  logic [NCHAN-1:0]             oob_err;

  modport master (
    output wr_en, wr_idx, wr_data, clr,
    input  out, valid, wr_count, oob_err
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, clr,
    output out, valid, wr_count, oob_err
  );
endinterface

// File: rtl/slicewrite_regbank.sv
// NCHAN independent register banks, each written one entry per cycle at a variable index.
module slicewrite_regbank #(
  parameter int NCHAN = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  slicewrite_regbank_if.slave  bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  for (genvar c = 0; c < NCHAN; c++) begin : g_bank
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_cnt;
    logic             r_oob;

    logic [IW-1:0]    w_idx;
    logic [WIDTH-1:0] w_data;
    logic             w_in_range;
    logic             w_acc;
    logic             w_oob;
    logic [CW-1:0]    w_cnt_base;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_idx      = bus.wr_idx[c*IW +: IW];
    assign w_data     = bus.wr_data[c*WIDTH +: WIDTH];
    assign w_in_range = ({1'b0, w_idx} < DEPTH_W);
    assign w_acc      = bus.wr_en[c] && w_in_range;
    assign w_oob      = bus.wr_en[c] && !w_in_range;

    // count restarts from zero on clear, then the accepted write bumps it (saturating)
    assign w_cnt_base = bus.clr[c] ? '0 : r_cnt;
    assign w_cnt_nxt  = (w_acc && !(&w_cnt_base)) ? w_cnt_base + CW'(1) : w_cnt_base;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
        r_valid <= '0;
        r_cnt   <= '0;
        r_oob   <= 1'b0;
      end else begin
        if (bus.clr[c]) begin
          for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
          r_valid <= '0;
        end
        // later NBA wins, so a same-cycle write overrides the clear
        if (w_acc) begin
          r_mem[w_idx]   <= w_data;
          r_valid[w_idx] <= 1'b1;
        end
        r_cnt <= w_cnt_nxt;
        if (w_oob) r_oob <= 1'b1;
      end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_out
      assign bus.out[(c*DEPTH+e)*WIDTH +: WIDTH] = r_mem[e];
    end
    assign bus.valid[c*DEPTH +: DEPTH] = r_valid;
    assign bus.wr_count[c*CW +: CW]    = r_cnt;
    assign bus.oob_err[c]              = r_oob;
  end
endmodule

// File: tb/tb_slicewrite_regbank.sv
// Scoreboard bench for slicewrite_regbank: default, DEPTH=3 and CW=2 instances share clk/rst.
module tb_slicewrite_regbank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slicewrite_regbank_if #(.NCHAN(4), .DEPTH(4), .WIDTH(4), .CW(8)) if0 ();
  slicewrite_regbank_if #(.NCHAN(4), .DEPTH(3), .WIDTH(4), .CW(8)) if1 ();
  slicewrite_regbank_if #(.NCHAN(4), .DEPTH(4), .WIDTH(4), .CW(2)) if2 ();

  slicewrite_regbank #(.NCHAN(4), .DEPTH(4), .WIDTH(4), .CW(8)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  slicewrite_regbank #(.NCHAN(4), .DEPTH(3), .WIDTH(4), .CW(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  slicewrite_regbank #(.NCHAN(4), .DEPTH(4), .WIDTH(4), .CW(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic [63:0] out;
    logic [15:0] val;
    logic [31:0] cnt;
    logic [3:0]  oob;
  } snap_t;

  snap_t q_exp[$];
  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] m_ent [3][4][4];
  logic       m_val [3][4][4];
  int         m_cnt [3][4];
  logic       m_oob [3][4];

  function automatic int depth_of(int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic int cw_of(int k);
    return (k == 2) ? 2 : 8;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[k][c] = 0;
        m_oob[k][c] = 1'b0;
        for (int e = 0; e < 4; e++) begin
          m_ent[k][c][e] = 4'h0;
          m_val[k][c][e] = 1'b0;
        end
      end
  endtask

  task automatic model_step(input int k, input logic [3:0] en, input logic [3:0] clr,
                            input logic [7:0] idx, input logic [15:0] dat);
    int d, mx, i;
    d  = depth_of(k);
    mx = (1 << cw_of(k)) - 1;
    for (int c = 0; c < 4; c++) begin
      if (clr[c]) begin
        m_cnt[k][c] = 0;
        for (int e = 0; e < 4; e++) begin
          m_ent[k][c][e] = 4'h0;
          m_val[k][c][e] = 1'b0;
        end
      end
      if (en[c] === 1'b1) begin
        i = int'(idx[c*2 +: 2]);
        if (i < d) begin
          m_ent[k][c][i] = dat[c*4 +: 4];
          m_val[k][c][i] = 1'b1;
          if (m_cnt[k][c] < mx) m_cnt[k][c]++;
        end else begin
          m_oob[k][c] = 1'b1;
        end
      end
    end
  endtask

  function automatic snap_t model_snap(input int k);
    snap_t s;
    int d, w;
    logic [31:0] cv;
    s = '0;
    d = depth_of(k);
    w = cw_of(k);
    for (int c = 0; c < 4; c++) begin
      for (int e = 0; e < d; e++) begin
        s.out[(c*d+e)*4 +: 4] = m_ent[k][c][e];
        s.val[c*d+e]          = m_val[k][c][e];
      end
      cv = 32'(m_cnt[k][c]);
      for (int b = 0; b < w; b++) s.cnt[c*w+b] = cv[b];
      s.oob[c] = m_oob[k][c];
    end
    return s;
  endfunction

  function automatic snap_t dut_snap(input int k);
    snap_t s;
    s = '0;
    case (k)
      0: begin s.out = if0.out; s.val = if0.valid; s.cnt = if0.wr_count; s.oob = if0.oob_err; end
      1: begin s.out = 64'(if1.out); s.val = 16'(if1.valid); s.cnt = if1.wr_count; s.oob = if1.oob_err; end
      default: begin s.out = if2.out; s.val = if2.valid; s.cnt = 32'(if2.wr_count); s.oob = if2.oob_err; end
    endcase
    return s;
  endfunction

  task automatic compare_snap(input string pfx, input snap_t got, input snap_t want);
    chk({pfx, "_out"},   got.out,         want.out);
    chk({pfx, "_valid"}, 64'(got.val),    64'(want.val));
    chk({pfx, "_count"}, 64'(got.cnt),    64'(want.cnt));
    chk({pfx, "_oob"},   64'(got.oob),    64'(want.oob));
  endtask

  task automatic drive(input int k, input logic [3:0] en, input logic [3:0] clr,
                       input logic [7:0] idx, input logic [15:0] dat);
    case (k)
      0: begin if0.wr_en = en; if0.clr = clr; if0.wr_idx = idx; if0.wr_data = dat; end
      1: begin if1.wr_en = en; if1.clr = clr; if1.wr_idx = idx; if1.wr_data = dat; end
      2: begin if2.wr_en = en; if2.clr = clr; if2.wr_idx = idx; if2.wr_data = dat; end
      default: ;
    endcase
  endtask

  // drive one instance (k<0: all idle), push expected snapshots, clock, pop and compare all three
  task automatic step(input int k, input logic [3:0] en, input logic [3:0] clr,
                      input logic [7:0] idx, input logic [15:0] dat);
    snap_t want;
    drive(k, en, clr, idx, dat);
    if (k >= 0) model_step(k, en, clr, idx, dat);
    for (int j = 0; j < 3; j++) q_exp.push_back(model_snap(j));
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      want = q_exp.pop_front();
      compare_snap($sformatf("i%0d", j), dut_snap(j), want);
    end
    for (int j = 0; j < 3; j++) drive(j, 4'h0, 4'h0, 8'h00, 16'h0000);
  endtask

  initial begin
    for (int j = 0; j < 3; j++) drive(j, 4'h0, 4'h0, 8'h00, 16'h0000);
    model_reset();

    // reset pulse before the first clock edge, then idle
    #2 rst = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) compare_snap($sformatf("rst_i%0d", j), dut_snap(j), '0);
    repeat (3) step(-1, 4'h0, 4'h0, 8'h00, 16'h0000);

    // parallel writes on all channels
    step(0, 4'hF, 4'h0, 8'b11_10_01_00, 16'hDCBA);
    chk("par_out",   if0.out,            64'hD000_0C00_00B0_000A);
    chk("par_valid", 64'(if0.valid),     64'h8421);
    chk("par_count", 64'(if0.wr_count),  64'h0101_0101);

    // hold and accumulate on bank 0 (fresh after clear)
    step(0, 4'h0, 4'h1, 8'h00, 16'h0000);
    step(0, 4'h1, 4'h0, 8'h02, 16'h0005);
    step(0, 4'h1, 4'h0, 8'h02, 16'h0007);
    step(0, 4'h1, 4'h0, 8'h00, 16'h0001);
    chk("acc_bank0", 64'(if0.out[15:0]),     64'h0701);
    chk("acc_valid", 64'(if0.valid[3:0]),    64'h5);
    chk("acc_count", 64'(if0.wr_count[7:0]), 64'd3);

    // load bank 1 with {1,2,3,4}, then clear+write, then clear alone
    step(0, 4'h2, 4'h2, 8'b00_00_00_00, 16'h0040);
    step(0, 4'h2, 4'h0, 8'b00_00_01_00, 16'h0030);
    step(0, 4'h2, 4'h0, 8'b00_00_10_00, 16'h0020);
    step(0, 4'h2, 4'h0, 8'b00_00_11_00, 16'h0010);
    chk("load_bank1", 64'(if0.out[31:16]), 64'h1234);
    step(0, 4'h2, 4'h2, 8'b00_00_11_00, 16'h0090);
    chk("cw_bank1", 64'(if0.out[31:16]),      64'h9000);
    chk("cw_valid", 64'(if0.valid[7:4]),      64'h8);
    chk("cw_count", 64'(if0.wr_count[15:8]),  64'd1);
    step(0, 4'h0, 4'h2, 8'h00, 16'h0000);
    chk("clr_bank1", 64'(if0.out[31:16]),     64'h0);
    chk("clr_count", 64'(if0.wr_count[15:8]), 64'd0);

    // disabled channels ignore X index/data
    step(0, 4'h0, 4'h0, 8'hxx, 16'hxxxx);

    // DEPTH=3: out-of-range index on channel 2
    step(1, 4'h4, 4'h0, 8'b00_01_00_00, 16'h0600);
    step(1, 4'h4, 4'h0, 8'b00_11_00_00, 16'h0F00);
    chk("oob_set",  64'(if1.oob_err),          64'h4);
    chk("oob_bank", 64'(if1.out[35:24]),       64'h060);
    chk("oob_cnt",  64'(if1.wr_count[23:16]),  64'd1);
    step(1, 4'h0, 4'h4, 8'h00, 16'h0000);
    chk("oob_sticky", 64'(if1.oob_err), 64'h4);

    // CW=2: saturation
    repeat (5) step(2, 4'h1, 4'h0, 8'h01, 16'h0003);
    chk("sat_count", 64'(if2.wr_count[1:0]), 64'd3);

    // async reset between edges
    rst = 1'b1;
    #1;
    model_reset();
    for (int j = 0; j < 3; j++) compare_snap($sformatf("arst_i%0d", j), dut_snap(j), '0);
    #1 rst = 1'b0;
    step(-1, 4'h0, 4'h0, 8'h00, 16'h0000);
    step(1, 4'h1, 4'h0, 8'h02, 16'h000C);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
